clb_cluster: RTL and testbench

Parametrised configurable logic block holding `NUM_LUTS` LUTs. Each LUT has per-input routing (neighbour, IO, intra-cluster feedback or constant) and an optional output flip-flop. The cluster is configured from a single serial bitstream with `tlast` framing checks. New configuration is staged in shadow registers and committed atomically, so the previous configuration stays live if a bitstream is malformed. It sits in the fabric tile array where a single-LUT CLB sat before.

---
 rtl/clb_cluster.sv | 158 +++++++++++++++
 tb/tb_clb_cluster.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_cluster.sv
`default_nettype none
// ============================================================================
// Module   : clb_cluster
// Brief    : Multi-LUT configurable logic block. Each LUT has routed inputs and
//            an optional output register. Configuration arrives as a serial
//            bitstream, is staged in shadow registers and committed atomically.
// Revision : 1.0 - initial release
// ============================================================================
module clb_cluster #(
    parameter int NUM_LUTS              = 2,
    parameter int LUT_WIDTH             = 4,
    parameter int NUM_NEIGHBOUR_SIGNALS = 8,
    parameter int NUM_IO_SIGNALS        = 4,
    parameter int SIGNAL_INDEX_W        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg,
    input  logic                             cfg_tvalid,
    input  logic                             cfg_tdata,
    input  logic                             cfg_tlast,
    output logic                             cfg_tready,
    output logic                             cfg_done,
    output logic                             cfg_error,
    output logic                             configured,
    input  logic                             run,
    input  logic [NUM_NEIGHBOUR_SIGNALS-1:0] run_in_neighbours,
    input  logic [NUM_IO_SIGNALS-1:0]        run_in_io,
    output logic [NUM_LUTS-1:0]              run_out
);

    localparam int c_IN_BITS    = 2 + SIGNAL_INDEX_W;
    localparam int c_TABLE_BITS = 1 << LUT_WIDTH;
    localparam int c_FRAME_BITS = LUT_WIDTH * c_IN_BITS + c_TABLE_BITS + 1;
    localparam int c_TOTAL_BITS = NUM_LUTS * c_FRAME_BITS;
    localparam int c_CNT_W      = $clog2(c_TOTAL_BITS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_TOTAL_BITS - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CONFIG = 2'd1;
    localparam logic [1:0] c_ST_ERROR  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_TOTAL_BITS-1:0] r_shadow;
    logic [c_TOTAL_BITS-1:0] w_shadow_next;
    logic [c_TOTAL_BITS-1:0] r_live;
    logic                    r_done;
    logic                    r_configured;
    logic [NUM_LUTS-1:0]     r_ff_q;
    logic [NUM_LUTS-1:0]     w_lut_comb;
    logic [NUM_LUTS-1:0]     w_ff_en;
    logic                    w_beat;
    logic                    w_start;
    logic                    w_commit;

    assign cfg_tready = (r_state == c_ST_CONFIG);
    assign cfg_error  = (r_state == c_ST_ERROR);
    assign cfg_done   = r_done;
    assign configured = r_configured;

    assign w_beat   = (r_state == c_ST_CONFIG) && cfg_tvalid;
    assign w_start  = cfg && ((r_state == c_ST_IDLE) || (r_state == c_ST_ERROR));
    assign w_commit = w_beat && (r_cnt == c_LAST) && cfg_tlast;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (cfg) w_state_next = c_ST_CONFIG;
            c_ST_CONFIG: begin
                if (w_beat) begin
                    if (r_cnt == c_LAST) w_state_next = cfg_tlast ? c_ST_IDLE : c_ST_ERROR;
                    else if (cfg_tlast)  w_state_next = c_ST_ERROR;
                end
            end
            c_ST_ERROR:  if (cfg) w_state_next = c_ST_CONFIG;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // The final beat must be part of the committed image, so commit from the
    // updated shadow rather than the registered one.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_beat) w_shadow_next[r_cnt] = cfg_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_live       <= '0;
            r_done       <= 1'b0;
            r_configured <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_start)     r_cnt <= '0;
            else if (w_beat) r_cnt <= r_cnt + 1'b1;
            if (w_beat)      r_shadow <= w_shadow_next;
            if (w_commit) begin
                r_live       <= w_shadow_next;
                r_configured <= 1'b1;
            end
        end
    end

    always_comb begin
        logic [LUT_WIDTH-1:0]      w_vec;
        logic [1:0]                w_type;
        logic [SIGNAL_INDEX_W-1:0] w_idx;
        logic [c_TABLE_BITS-1:0]   w_table;
        logic                      w_sel;
        int                        v_base;
        int                        v_off;
        w_lut_comb = '0;
        w_ff_en    = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            v_base = i * c_FRAME_BITS;
            w_vec  = '0;
            for (int j = 0; j < LUT_WIDTH; j++) begin
                v_off  = v_base + j * c_IN_BITS;
                w_type = r_live[v_off +: 2];
                w_idx  = r_live[v_off + 2 +: SIGNAL_INDEX_W];
                w_sel  = 1'b0;
                // Out-of-range indices match no source and leave w_sel at 0.
                case (w_type)
                    2'd0: for (int k = 0; k < NUM_NEIGHBOUR_SIGNALS; k++)
                              if (w_idx == SIGNAL_INDEX_W'(k)) w_sel = run_in_neighbours[k];
                    2'd1: for (int k = 0; k < NUM_IO_SIGNALS; k++)
                              if (w_idx == SIGNAL_INDEX_W'(k)) w_sel = run_in_io[k];
                    2'd2: for (int k = 0; k < NUM_LUTS; k++)
                              if (w_idx == SIGNAL_INDEX_W'(k)) w_sel = r_ff_q[k];
                    default: w_sel = w_idx[0];
                endcase
                w_vec[j] = w_sel;
            end
            w_table       = r_live[v_base + LUT_WIDTH * c_IN_BITS +: c_TABLE_BITS];
            w_lut_comb[i] = w_table[w_vec];
            w_ff_en[i]    = r_live[v_base + LUT_WIDTH * c_IN_BITS + c_TABLE_BITS];
        end
    end

    // Feedback always taps the register, so comb-mode LUTs cannot form loops.
    always_ff @(posedge clk) begin
        if (rst)                                r_ff_q <= '0;
        else if (run && (r_state == c_ST_IDLE)) r_ff_q <= w_lut_comb;
    end

    assign run_out = (w_ff_en & r_ff_q) | (~w_ff_en & w_lut_comb);

endmodule
`default_nettype wire

// File: tb/tb_clb_cluster.sv
`default_nettype none
// ============================================================================
// Module   : tb_clb_cluster
// Brief    : Randomized bench for clb_cluster with a decoded-field reference
//            model and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clb_cluster;

    localparam int NL   = 2;
    localparam int LW   = 4;
    localparam int NN   = 8;
    localparam int NIO  = 4;
    localparam int SIW  = 8;
    localparam int TABB = 1 << LW;
    localparam int FRB  = LW * (2 + SIW) + TABB + 1;
    localparam int TOT  = NL * FRB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg = 1'b0;
    logic           cfg_tvalid = 1'b0;
    logic           cfg_tdata = 1'b0;
    logic           cfg_tlast = 1'b0;
    logic           cfg_tready;
    logic           cfg_done;
    logic           cfg_error;
    logic           configured;
    logic           run = 1'b0;
    logic [NN-1:0]  run_in_neighbours = '0;
    logic [NIO-1:0] run_in_io = '0;
    logic [NL-1:0]  run_out;

    clb_cluster #(
        .NUM_LUTS(NL), .LUT_WIDTH(LW), .NUM_NEIGHBOUR_SIGNALS(NN),
        .NUM_IO_SIGNALS(NIO), .SIGNAL_INDEX_W(SIW)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg(cfg), .cfg_tvalid(cfg_tvalid),
        .cfg_tdata(cfg_tdata), .cfg_tlast(cfg_tlast), .cfg_tready(cfg_tready),
        .cfg_done(cfg_done), .cfg_error(cfg_error), .configured(configured),
        .run(run), .run_in_neighbours(run_in_neighbours), .run_in_io(run_in_io),
        .run_out(run_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus-side description of the configuration to send.
    int             s_type [NL][LW];
    int             s_idx  [NL][LW];
    logic [TABB-1:0] s_tab [NL];
    bit             s_ff   [NL];

    // Reference model: decoded live fields, registered outputs, protocol mode.
    int             m_type [NL][LW];
    int             m_idx  [NL][LW];
    logic [TABB-1:0] m_tab [NL];
    bit             m_ff   [NL];
    logic [NL-1:0]  m_ffq  = '0;
    int             m_mode = 0;   // 0 idle, 1 receiving, 2 error
    bit             m_done = 0;
    bit             m_conf = 0;
    bit             q [$];
    bit             chk_en = 0;
    bit             rnd_en = 0;

    function automatic logic src(input int t, input int idx);
        case (t)
            0:       return (idx < NN)  ? run_in_neighbours[idx] : 1'b0;
            1:       return (idx < NIO) ? run_in_io[idx] : 1'b0;
            2:       return (idx < NL)  ? m_ffq[idx] : 1'b0;
            default: return 1'(idx % 2);
        endcase
    endfunction

    function automatic logic m_comb(input int i);
        int vec = 0;
        for (int j = 0; j < LW; j++) vec += int'(src(m_type[i][j], m_idx[i][j])) << j;
        return m_tab[i][vec];
    endfunction

    function automatic int field(input int pos, input int w);
        int v = 0;
        for (int b = 0; b < w; b++) v += int'(q[pos + b]) << b;
        return v;
    endfunction

    task automatic m_commit();
        int p = 0;
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < LW; j++) begin
                m_type[i][j] = field(p, 2);   p += 2;
                m_idx[i][j]  = field(p, SIW); p += SIW;
            end
            for (int b = 0; b < TABB; b++) m_tab[i][b] = q[p + b];
            p += TABB;
            m_ff[i] = q[p]; p++;
        end
    endtask

    always @(posedge clk) begin
        logic [NL-1:0] nf;
        if (rst) begin
            m_mode = 0; m_done = 0; m_conf = 0; m_ffq = '0; q.delete();
            for (int i = 0; i < NL; i++) begin
                m_tab[i] = '0; m_ff[i] = 0;
                for (int j = 0; j < LW; j++) begin m_type[i][j] = 0; m_idx[i][j] = 0; end
            end
        end else begin
            m_done = 0;
            for (int i = 0; i < NL; i++) nf[i] = m_comb(i);
            if (run && m_mode == 0) m_ffq = nf;
            if (m_mode != 1) begin
                if (cfg) begin m_mode = 1; q.delete(); end
            end else if (cfg_tvalid) begin
                q.push_back(cfg_tdata);
                if (q.size() == TOT) begin
                    if (cfg_tlast) begin m_commit(); m_conf = 1; m_done = 1; m_mode = 0; end
                    else m_mode = 2;
                end else if (cfg_tlast) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        logic [NL-1:0] eo;
        if (chk_en) begin
            for (int i = 0; i < NL; i++) eo[i] = m_ff[i] ? m_ffq[i] : m_comb(i);
            chk("cfg_tready", cfg_tready, (m_mode == 1));
            chk("cfg_error",  cfg_error,  (m_mode == 2));
            chk("cfg_done",   cfg_done,   m_done);
            chk("configured", configured, m_conf);
            chk("run_out",    run_out,    eo);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_en) begin
            run               = 1'($urandom);
            run_in_neighbours = NN'($urandom);
            run_in_io         = NIO'($urandom);
        end
    end

    function automatic logic [TOT-1:0] pack();
        logic [TOT-1:0] s = '0;
        int p = 0;
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < LW; j++) begin
                for (int b = 0; b < 2; b++)   begin s[p] = 1'(s_type[i][j] >> b); p++; end
                for (int b = 0; b < SIW; b++) begin s[p] = 1'(s_idx[i][j] >> b);  p++; end
            end
            for (int b = 0; b < TABB; b++) begin s[p] = s_tab[i][b]; p++; end
            s[p] = s_ff[i]; p++;
        end
        return s;
    endfunction

    task automatic set_zero();
        for (int i = 0; i < NL; i++) begin
            s_tab[i] = '0; s_ff[i] = 0;
            for (int j = 0; j < LW; j++) begin s_type[i][j] = 0; s_idx[i][j] = 0; end
        end
    endtask

    task automatic set_and();
        set_zero();
        s_type[0][0] = 1; s_idx[0][0] = 0;
        s_type[0][1] = 1; s_idx[0][1] = 1;
        s_type[0][2] = 3; s_idx[0][2] = 1;
        s_type[0][3] = 3; s_idx[0][3] = 1;
        s_tab[0] = 16'h8888;
    endtask

    task automatic set_toggle();
        set_zero();
        s_type[0][0] = 2; s_idx[0][0] = 0;
        for (int j = 1; j < LW; j++) s_type[0][j] = 3;
        s_tab[0] = 16'h5555;
        s_ff[0]  = 1;
    endtask

    task automatic set_random();
        for (int i = 0; i < NL; i++) begin
            s_tab[i] = TABB'($urandom);
            s_ff[i]  = 1'($urandom);
            for (int j = 0; j < LW; j++) begin
                s_type[i][j] = $urandom_range(3);
                s_idx[i][j]  = $urandom_range(15);
            end
        end
    endtask

    // Sends beats 0..nbeats-1 of s; tlast is raised on beat tlast_at.
    task automatic send(input logic [TOT-1:0] s, input int nbeats, input int tlast_at,
                        input int duty, input bit chk_done);
        int  k = 0;
        int  guard = 0;
        bit  acc;
        @(posedge clk); #1;
        cfg = 1'b1;
        @(posedge clk); #1;
        cfg = 1'b0;
        while (k < nbeats && guard < 5000) begin
            guard++;
            cfg_tvalid = ($urandom_range(99) < duty);
            cfg_tdata  = s[k];
            cfg_tlast  = (k == tlast_at);
            acc = cfg_tvalid && cfg_tready;
            @(posedge clk); #1;
            if (acc) k++;
            if (acc && k < nbeats && !cfg_tready) break;
        end
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
        if (guard >= 5000) chk("send_timeout", 32'(guard), 32'(0));
        if (chk_done) begin
            chk("lit_done_pulse", cfg_done, 1);
            chk("lit_ready_after", cfg_tready, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rnd_en = 1;
        repeat (2) @(posedge clk);
        chk_en = 1;
        #1;
        chk("lit_reset_out", run_out, 0);
        chk("lit_reset_ready", cfg_tready, 0);
        chk("lit_reset_conf", configured, 0);
        rst = 1'b0;

        rnd_en = 0; run = 0;
        set_and();
        send(pack(), TOT, TOT - 1, 100, 1);
        chk("lit_and_conf", configured, 1);
        run_in_io = 4'b0011; #1;
        chk("lit_and_11", run_out[0], 1);
        run_in_io = 4'b0001; #1;
        chk("lit_and_01", run_out[0], 0);

        rnd_en = 1;
        repeat (4) begin
            set_random();
            send(pack(), TOT, TOT - 1, 50, 1);
            repeat (20) @(posedge clk);
        end

        do_reset();
        rnd_en = 0; run = 0;
        set_toggle();
        send(pack(), TOT, TOT - 1, 100, 1);
        run = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("lit_toggle", run_out[0], (c % 2 == 0) ? 1 : 0);
        end
        run = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("lit_toggle_hold", run_out[0], 0);
        end

        set_and();
        send(pack(), TOT, TOT - 1, 100, 1);
        send(pack(), TOT, 49, 100, 0);
        chk("lit_early_err", cfg_error, 1);
        chk("lit_early_ready", cfg_tready, 0);
        chk("lit_early_conf", configured, 1);
        run_in_io = 4'b0011; #1;
        chk("lit_early_and", run_out[0], 1);

        send(pack(), TOT, -1, 100, 0);
        chk("lit_notlast_err", cfg_error, 1);
        send(pack(), TOT, TOT - 1, 100, 1);
        chk("lit_recover_err", cfg_error, 0);

        rnd_en = 1;
        set_and();
        send(pack(), TOT, TOT - 1, 50, 1);
        rnd_en = 0; run = 0;
        run_in_io = 4'b0011; #1;
        chk("lit_bp_and", run_out[0], 1);

        rnd_en = 1;
        set_random();
        send(pack(), 60, -1, 50, 0);
        do_reset();
        chk("lit_midrst_conf", configured, 0);
        chk("lit_midrst_out", run_out, 0);
        chk("lit_midrst_ready", cfg_tready, 0);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
